multichannel_adc_capture: RTL and testbench

MULTICHANNEL_ADC_CAPTURE -- requirements
Module: multichannel_adc_capture

---
 rtl/multichannel_adc_capture_if.sv | 26 ++
 rtl/multichannel_adc_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_multichannel_adc_capture.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multichannel_adc_capture_if.sv
// Capture-block bus: ADC frame input, command port and word-serial readout.
// The master side is the ADC/command source and readout sink; the slave is the capture block.
interface multichannel_adc_capture_if #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 4
);
    logic [NUM_CH*DATA_W-1:0] adc_data;
    logic                     adc_valid;
    logic [7:0]               cmd_opcode;
    logic [31:0]              cmd_data;
    logic                     cmd_valid;
    logic [31:0]              tx_data;
    logic                     tx_en;
    logic                     tx_done;
    logic [7:0]               status;

    modport master (
        output adc_data, adc_valid, cmd_opcode, cmd_data, cmd_valid, tx_done,
        input  tx_data, tx_en, status
    );

    modport slave (
        input  adc_data, adc_valid, cmd_opcode, cmd_data, cmd_valid, tx_done,
        output tx_data, tx_en, status
    );
endinterface

// File: rtl/multichannel_adc_capture.sv
// Triggered multichannel ADC capture into a circular frame buffer with
// pre/post-trigger windows, decimation and channel-serial readout.
module multichannel_adc_capture #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 1024
) (
    input logic clk,
    input logic rst_n,
    multichannel_adc_capture_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [DATA_W-1:0] LEVEL_RST = DATA_W'(1 << (DATA_W - 1));
    localparam logic [7:0] OP_ARM = 8'h21, OP_ABORT = 8'h22, OP_CFG = 8'h23, OP_DEC = 8'h24,
                           OP_LVL = 8'h25, OP_READ = 8'h26, OP_PRE = 8'h28, OP_POST = 8'h29;

    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3,
                              DONE = 3'd4, READ = 3'd5} state_t;
    typedef enum logic [1:0] {RD_WAIT, RD_LOAD, RD_SEND} rd_phase_t;

    state_t                   state_reg;
    rd_phase_t                rd_phase_reg;
    logic [AW-1:0]            wr_ptr_reg, trig_ptr_reg, rd_addr_reg;
    logic [CW-1:0]            pre_cnt_reg, post_cnt_reg, pre_eff_reg, post_eff_reg, rd_left_reg;
    logic [15:0]              dec_cnt_reg, dec_reg;
    logic [1:0]               trig_mode_reg;
    logic [3:0]               trig_ch_reg, ch_idx_reg;
    logic [DATA_W-1:0]        level_reg, last_reg;
    logic [31:0]              pre_cfg_reg, post_cfg_reg, tx_data_reg;
    logic                     tx_en_reg, triggered_reg;

    logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
    logic [NUM_CH*DATA_W-1:0] rd_q_reg;

    logic [DATA_W-1:0] in_ch [NUM_CH];
    logic [DATA_W-1:0] rd_ch [NUM_CH];
    logic [DATA_W-1:0] trig_s, rd_s;
    logic [CW-1:0]     pre_clip, post_clip;
    logic [31:0]       tx_word;
    logic              capturing, frame_acc, trig_hit, cfg_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign in_ch[gi] = bus.adc_data[gi*DATA_W +: DATA_W];
            assign rd_ch[gi] = rd_q_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        trig_s = '0;
        rd_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_ch_reg == 4'(i)) trig_s = in_ch[i];
            if (ch_idx_reg == 4'(i))  rd_s   = rd_ch[i];
        end
        tx_word                 = '0;
        tx_word[31:28]          = ch_idx_reg;
        tx_word[DATA_W-1:0]     = rd_s;
    end

    assign capturing = (state_reg == PRE) || (state_reg == ARMED) || (state_reg == POST);
    assign frame_acc = capturing && bus.adc_valid && (dec_cnt_reg == 16'd0);
    assign cfg_ok    = (state_reg == IDLE) || (state_reg == DONE);

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode_reg)
            2'd0: trig_hit = 1'b1;
            2'd1: trig_hit = (last_reg < level_reg) && (trig_s >= level_reg);
            2'd2: trig_hit = (last_reg >= level_reg) && (trig_s < level_reg);
            2'd3: trig_hit = (trig_s >= level_reg);
            default: trig_hit = 1'b0;
        endcase
    end

    // Window clipping: pre leaves room for at least one post frame, total never exceeds the buffer.
    always_comb begin
        pre_clip  = (pre_cfg_reg >= 32'(DEPTH)) ? CW'(DEPTH - 1) : CW'(pre_cfg_reg);
        post_clip = (post_cfg_reg == 32'd0) ? CNT_ONE :
                    (post_cfg_reg >= 32'(DEPTH)) ? CW'(DEPTH) : CW'(post_cfg_reg);
        if ((CW+1)'(pre_clip) + (CW+1)'(post_clip) > (CW+1)'(DEPTH))
            post_clip = CW'(DEPTH) - pre_clip;
    end

    always_ff @(posedge clk) begin
        if (frame_acc) mem[wr_ptr_reg] <= bus.adc_data;
        rd_q_reg <= mem[rd_addr_reg];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rd_phase_reg  <= RD_WAIT;
            wr_ptr_reg    <= '0;
            trig_ptr_reg  <= '0;
            rd_addr_reg   <= '0;
            pre_cnt_reg   <= '0;
            post_cnt_reg  <= '0;
            pre_eff_reg   <= '0;
            post_eff_reg  <= CNT_ONE;
            rd_left_reg   <= '0;
            dec_cnt_reg   <= '0;
            dec_reg       <= '0;
            trig_mode_reg <= '0;
            trig_ch_reg   <= '0;
            ch_idx_reg    <= '0;
            level_reg     <= LEVEL_RST;
            last_reg      <= '0;
            pre_cfg_reg   <= '0;
            post_cfg_reg  <= 32'd1;
            tx_data_reg   <= '0;
            tx_en_reg     <= 1'b0;
            triggered_reg <= 1'b0;
        end else if (bus.cmd_valid && bus.cmd_opcode == OP_ABORT) begin
            state_reg     <= IDLE;
            tx_en_reg     <= 1'b0;
            triggered_reg <= 1'b0;
        end else begin
            if (bus.cmd_valid && cfg_ok) begin
                case (bus.cmd_opcode)
                    OP_CFG: begin
                        trig_mode_reg <= bus.cmd_data[1:0];
                        trig_ch_reg   <= bus.cmd_data[7:4];
                    end
                    OP_DEC:  dec_reg      <= bus.cmd_data[15:0];
                    OP_LVL:  level_reg    <= bus.cmd_data[DATA_W-1:0];
                    OP_PRE:  pre_cfg_reg  <= bus.cmd_data;
                    OP_POST: post_cfg_reg <= bus.cmd_data;
                    default: ;
                endcase
            end

            if (capturing && bus.adc_valid)
                dec_cnt_reg <= (dec_cnt_reg >= dec_reg) ? 16'd0 : dec_cnt_reg + 16'd1;
            if (frame_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                last_reg   <= trig_s;
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (bus.cmd_valid && bus.cmd_opcode == OP_ARM) begin
                        state_reg     <= PRE;
                        wr_ptr_reg    <= '0;
                        pre_cnt_reg   <= '0;
                        post_cnt_reg  <= '0;
                        dec_cnt_reg   <= '0;
                        last_reg      <= '0;
                        triggered_reg <= 1'b0;
                        pre_eff_reg   <= pre_clip;
                        post_eff_reg  <= post_clip;
                    end else if (state_reg == DONE && bus.cmd_valid && bus.cmd_opcode == OP_READ) begin
                        state_reg    <= READ;
                        rd_phase_reg <= RD_WAIT;
                        rd_addr_reg  <= trig_ptr_reg - pre_eff_reg[AW-1:0];
                        rd_left_reg  <= pre_eff_reg + post_eff_reg;
                        ch_idx_reg   <= '0;
                        tx_en_reg    <= 1'b0;
                    end
                end
                PRE: begin
                    if (frame_acc) pre_cnt_reg <= pre_cnt_reg + CNT_ONE;
                    if (pre_eff_reg == '0 || (frame_acc && pre_cnt_reg + CNT_ONE == pre_eff_reg))
                        state_reg <= ARMED;
                end
                ARMED: begin
                    if (frame_acc && trig_hit) begin
                        trig_ptr_reg  <= wr_ptr_reg;
                        triggered_reg <= 1'b1;
                        post_cnt_reg  <= CNT_ONE;
                        state_reg     <= (post_eff_reg <= CNT_ONE) ? DONE : POST;
                    end
                end
                POST: begin
                    if (frame_acc) begin
                        post_cnt_reg <= post_cnt_reg + CNT_ONE;
                        if (post_cnt_reg + CNT_ONE == post_eff_reg) state_reg <= DONE;
                    end
                end
                READ: begin
                    // One idle cycle after an address change lets the registered RAM output settle.
                    case (rd_phase_reg)
                        RD_WAIT: rd_phase_reg <= RD_LOAD;
                        RD_LOAD: begin
                            tx_data_reg  <= tx_word;
                            tx_en_reg    <= 1'b1;
                            rd_phase_reg <= RD_SEND;
                        end
                        default: begin
                            if (bus.tx_done) begin
                                tx_en_reg <= 1'b0;
                                if (ch_idx_reg == 4'(NUM_CH - 1)) begin
                                    ch_idx_reg  <= '0;
                                    rd_left_reg <= rd_left_reg - CNT_ONE;
                                    if (rd_left_reg == CNT_ONE) begin
                                        state_reg <= DONE;
                                    end else begin
                                        rd_addr_reg  <= rd_addr_reg + AW'(1);
                                        rd_phase_reg <= RD_WAIT;
                                    end
                                end else begin
                                    ch_idx_reg   <= ch_idx_reg + 4'd1;
                                    rd_phase_reg <= RD_LOAD;
                                end
                            end
                        end
                    endcase
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.tx_data = tx_data_reg;
    assign bus.tx_en   = tx_en_reg;
    assign bus.status  = {4'b0000, triggered_reg, state_reg};
endmodule

// File: tb/tb_multichannel_adc_capture.sv
// Directed bench for multichannel_adc_capture: a frame-level model predicts the readout
// word stream, and a per-cycle monitor checks words, hold stability and inter-word gaps.
`timescale 1ns/1ps
module tb_multichannel_adc_capture;
    localparam int DATA_W = 12;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multichannel_adc_capture_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();
    multichannel_adc_capture #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int m_mode, m_ch, m_dec, m_lvl, m_pre, m_post, gen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Stimulus sample for frame k, channel c, under pattern g.
    function automatic int samp(input int g, input int k, input int c);
        case (g)
            0:       return (16 * k + c) & 32'hFFF;
            1:       return (32'h77C + k + 32'h40 * c) & 32'hFFF;
            default: return (k + 16 * c) & 32'hFFF;
        endcase
    endfunction

    function automatic void model_defaults();
        m_mode = 0; m_ch = 0; m_dec = 0; m_lvl = 32'h800; m_pre = 0; m_post = 1;
    endfunction

    // Accepted frame j is stream frame j*(dec+1); first pre accepted frames are history,
    // the trigger is searched from there, and the window spans pre+post accepted frames.
    task automatic build_exp();
        int pre_e, post_e, t, s, p;
        bit hit;
        pre_e  = (m_pre >= DEPTH) ? DEPTH - 1 : m_pre;
        post_e = (m_post == 0) ? 1 : m_post;
        if (pre_e + post_e > DEPTH) post_e = DEPTH - pre_e;
        t = -1;
        for (int j = pre_e; j < 8192 && t < 0; j++) begin
            s = samp(gen, j * (m_dec + 1), m_ch);
            p = (j > 0) ? samp(gen, (j - 1) * (m_dec + 1), m_ch) : 0;
            case (m_mode)
                0:       hit = 1'b1;
                1:       hit = (p < m_lvl) && (s >= m_lvl);
                2:       hit = (p >= m_lvl) && (s < m_lvl);
                default: hit = (s >= m_lvl);
            endcase
            if (hit) t = j;
        end
        exp_q.delete();
        if (t >= 0)
            for (int j = t - pre_e; j < t + post_e; j++)
                for (int c = 0; c < NUM_CH; c++)
                    exp_q.push_back({4'(c), 4'h0, 24'(samp(gen, j * (m_dec + 1), c))});
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] data);
        bus.cmd_opcode = op;
        bus.cmd_data   = data;
        bus.cmd_valid  = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        $display("cmd op=0x%02h data=0x%08h status=0x%02h", op, data, bus.status);
    endtask

    task automatic set_cfg(input int mode, input int ch, input int dec, input int lvl,
                           input int pre, input int post);
        send_cmd(8'h23, 32'((ch << 4) | mode));
        send_cmd(8'h24, 32'(dec));
        send_cmd(8'h25, 32'(lvl));
        send_cmd(8'h28, 32'(pre));
        send_cmd(8'h29, 32'(post));
        m_mode = mode; m_ch = ch; m_dec = dec; m_lvl = lvl; m_pre = pre; m_post = post;
    endtask

    task automatic drive_frame(input int k);
        logic [NUM_CH*DATA_W-1:0] f;
        for (int c = 0; c < NUM_CH; c++) f[c*DATA_W +: DATA_W] = DATA_W'(samp(gen, k, c));
        bus.adc_data  = f;
        bus.adc_valid = 1'b1;
    endtask

    task automatic capture(input string name, output int nfr);
        send_cmd(8'h21, 32'd0);
        @(posedge clk); #1;
        nfr = 0;
        for (int n = 0; n < 5000; n++) begin
            drive_frame(nfr);
            @(posedge clk); #1;
            nfr++;
            if (bus.status[2:0] == 3'd4) break;
        end
        bus.adc_valid = 1'b0;
        $display("capture %s frames=%0d status=0x%02h", name, nfr, bus.status);
        chk({name, "_done"}, 32'(bus.status[2:0]), 32'd4);
    endtask

    task automatic readout(input string name, input bit random_done);
        send_cmd(8'h26, 32'd0);
        for (int n = 0; n < 30000; n++) begin
            bus.tx_done = random_done ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (exp_q.size() == 0 && bus.status[2:0] == 3'd4) break;
        end
        bus.tx_done = 1'b0;
        $display("readout %s words_left=%0d status=0x%02h", name, exp_q.size(), bus.status);
        chk({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_end_state"}, 32'(bus.status[2:0]), 32'd4);
        chk({name, "_end_tx_en"}, 32'(bus.tx_en), 32'd0);
    endtask

    // Per-cycle monitor: word order/content, hold stability, next-word latency.
    logic [31:0] prev_data, mon_e;
    logic        prev_en, prev_done, gap_act;
    int          gap;
    initial begin
        prev_en = 1'b0; prev_done = 1'b0; prev_data = '0; gap_act = 1'b0; gap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0;
                gap_act = 1'b0;
            end else begin
                if (bus.tx_en) begin
                    if (prev_en && !prev_done) begin
                        chk("tx_stable", bus.tx_data, prev_data);
                    end else if (gap_act) begin
                        chk("tx_gap_le3", 32'(gap <= 2), 32'd1);
                        gap_act = 1'b0;
                    end
                    if (bus.tx_done) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL tx_extra_word actual=0x%08h required=none", bus.tx_data);
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk("tx_word", bus.tx_data, mon_e);
                        end
                        gap_act = 1'b1;
                        gap = 0;
                    end
                end else if (gap_act) begin
                    if (bus.status[2:0] == 3'd5) gap++;
                    else gap_act = 1'b0;
                end
                prev_en   = bus.tx_en;
                prev_done = bus.tx_done;
                prev_data = bus.tx_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] t2_lit [7] = '{32'h200007FD, 32'h200007FE, 32'h200007FF, 32'h20000800,
                                32'h20000801, 32'h20000802, 32'h20000803};
    logic [31:0] held;
    int nfr;

    initial begin
        bus.adc_data = '0; bus.adc_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_data = '0;
        bus.cmd_valid = 1'b0; bus.tx_done = 1'b0;
        model_defaults();
        #12;
        chk("rst_status", 32'(bus.status), 32'h00);
        chk("rst_tx_en", 32'(bus.tx_en), 32'd0);
        chk("rst_tx_data", bus.tx_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Defaults, immediate trigger: one frame, four words.
        gen = 0;
        capture("t1", nfr);
        chk("t1_status", 32'(bus.status), 32'h0C);
        build_exp();
        chk("t1_nwords", 32'(exp_q.size()), 32'd4);
        chk("t1_w0", exp_q[0], 32'h00000000);
        chk("t1_w3", exp_q[3], 32'h30000003);
        readout("t1", 1'b0);

        // Rising trigger on channel 2 with pre/post window.
        gen = 1;
        set_cfg(1, 2, 0, 32'h800, 3, 4);
        capture("t2", nfr);
        chk("t2_frames", 32'(nfr), 32'd8);
        build_exp();
        chk("t2_nwords", 32'(exp_q.size()), 32'd28);
        for (int i = 0; i < 7; i++) chk("t2_ch2", exp_q[4*i+2], t2_lit[i]);
        readout("t2", 1'b1);

        // Decimation by 3, immediate trigger.
        gen = 0;
        set_cfg(0, 0, 2, 32'h800, 0, 3);
        capture("t3", nfr);
        build_exp();
        chk("t3_nwords", 32'(exp_q.size()), 32'd12);
        chk("t3_f0", exp_q[4], 32'h00000030);
        chk("t3_f1", exp_q[8], 32'h00000060);
        readout("t3", 1'b1);

        // Oversized window: post clipped to 24, trigger wraps the start address.
        gen = 2;
        set_cfg(1, 0, 0, 32'h800, 1000, 100);
        capture("t4", nfr);
        chk("t4_frames", 32'(nfr), 32'd2072);
        chk("t4_status", 32'(bus.status), 32'h0C);
        build_exp();
        chk("t4_nwords", 32'(exp_q.size()), 32'd4096);
        chk("t4_first", exp_q[0], 32'h00000418);
        chk("t4_last", exp_q[4095], 32'h30000847);
        readout("t4", 1'b0);

        // Re-read, stall the sink, then abort mid-readout.
        build_exp();
        send_cmd(8'h26, 32'd0);
        bus.tx_done = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() > 4090; n++) begin
            @(posedge clk); #1;
        end
        bus.tx_done = 1'b0;
        for (int n = 0; n < 10 && !bus.tx_en; n++) begin
            @(posedge clk); #1;
        end
        chk("t5_tx_en_before_hold", 32'(bus.tx_en), 32'd1);
        held = bus.tx_data;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("t5_hold_data", bus.tx_data, held);
        chk("t5_hold_en", 32'(bus.tx_en), 32'd1);
        send_cmd(8'h22, 32'd0);
        chk("t5_abort_status", 32'(bus.status), 32'h00);
        chk("t5_abort_tx_en", 32'(bus.tx_en), 32'd0);
        exp_q.delete();

        // Asynchronous reset while in POST, then a clean capture with reset defaults.
        gen = 0;
        set_cfg(0, 0, 0, 32'h800, 0, 50);
        send_cmd(8'h21, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            drive_frame(k);
            @(posedge clk); #1;
        end
        bus.adc_valid = 1'b0;
        chk("t6_post_status", 32'(bus.status), 32'h0B);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_status", 32'(bus.status), 32'h00);
        chk("t6_async_tx_en", 32'(bus.tx_en), 32'd0);
        chk("t6_async_tx_data", bus.tx_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_defaults();
        @(posedge clk); #1;
        chk("t6_idle", 32'(bus.status), 32'h00);
        capture("t6", nfr);
        build_exp();
        chk("t6_nwords", 32'(exp_q.size()), 32'd4);
        readout("t6", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
